note_detector: RTL and testbench
================================

Name: note_detector

Overview:
- Receive-side counterpart of the tone generators in musica_juego. The tone generators divide clock_in into note square waves; this block takes a square wave back in and measures its period in clock_in cycles.
- It classifies the period against the eight-note scale table, do through do' (upper do). It reports the detected note once the note has been stable for several periods.
- Used by the game to check player or loop-back audio, and by benches as a self-checking monitor on generator outputs.

Parameters:
- CNT_W, 28, width of the period counter and of period_out.
- TOL_SHIFT, 6, match tolerance: |period - nominal| <= nominal >> TOL_SHIFT (about 1.6 %).
- LOCK_COUNT, 4, number of consecutive matching periods, all the same note, required before note_valid asserts.
- TIMEOUT, 200000, number of cycles without a rising edge before the input is declared silent.

Ports:
- clock_in  input  1  system clock, 50 MHz.
- reset_n  input  1  asynchronous, active-low reset.
- tone_in  input  1  square wave under test; asynchronous to clock_in.
- period_out  output  CNT_W  last measured period, in clock_in cycles.
- period_strobe  output  1  one-cycle pulse when period_out updates.
- note_id  output  3  detected note: 0=do, 1=re, 2=mi, 3=fa, 4=sol, 5=la, 6=si, 7=do'.
- note_valid  output  1  high while the detector is locked on note_id.
- silent  output  1  high when no edge has arrived within TIMEOUT cycles.

Behaviour:
Reset and clocking:
- One clock, clock_in. Reset is reset_n, asynchronous and active-low.
- Reset values:
  - period_out = 0, period_strobe = 0
  - note_id = 0, note_valid = 0
  - silent = 1
  - state = IDLE, counters = 0, synchroniser flops = 0

Edge detection:
- tone_in passes through a 2-flop synchroniser, then a third flop for edge detection.
- rise = sync & ~prev.

Period measurement:
- cnt increments every cycle and saturates at TIMEOUT.
- On rise: period = cnt + 1, then cnt is cleared to 0.
- An ideal generator with DIVISOR = D gives period = D exactly.
- period_out and period_strobe update on the cycle after rise.
- No update is made on the first rise after IDLE, because there is no reference edge yet.

Classification:
- Combinational comparison of the registered period against the package table.
- The lowest index wins if two entries overlap.
- If no entry matches, the period is non-matching.
- Subtraction uses CNT_W+1 bits; the absolute value is taken before comparing.

State machine:
- IDLE:
  - silent = 1, note_valid = 0.
  - On rise: go to ACQUIRE, match_cnt = 0, silent = 0.
- ACQUIRE:
  - On each measured period:
    - If it matches the same note as cand: match_cnt++.
    - If it matches a different note: cand = new note, match_cnt = 1.
    - If it matches nothing: match_cnt = 0.
  - When match_cnt reaches LOCK_COUNT: go to LOCKED, note_id = cand, note_valid = 1.
  - This happens in the same cycle as the strobe that satisfies the count.
- LOCKED:
  - A matching period of the same note keeps the lock.
  - One non-matching period or a different note drops to ACQUIRE with note_valid = 0 on the next cycle.
  - A different note is reloaded as cand with match_cnt = 1.
  - note_id holds its last value.
- Any state: when cnt reaches TIMEOUT, go to IDLE.
  - silent = 1, note_valid = 0.
  - period_out is held.

Boundary conditions:
- rise in the same cycle as the timeout: the edge wins and the timeout is ignored.
- A period of 1 or 2 cycles (glitch) is measured normally; it is non-matching.
- Counter saturation prevents wrap-around.
- Reset asserted mid-measurement returns every register to its reset value immediately.

Decomposition:
- Package note_pkg:
  - localparam NOTE_PERIOD[0..7] = 95602, 85131, 75843, 71586, 63776, 56818, 50619, 47778.
  - Note index constants NOTE_DO through NOTE_DO2.
  - State encoding IDLE / ACQUIRE / LOCKED.
- Sub-module note_classifier (combinational): period in, match and index out, parameterised by TOL_SHIFT.
- The top level holds the synchroniser, counter and FSM.

Test Plan:
- Reset: hold reset_n = 0 with tone_in toggling -> all outputs at reset values; silent = 1.
- Drive an ideal do3 wave (95602-cycle period, 50 % duty) -> period_strobe each period with period_out = 95602; note_valid = 1, note_id = 0 on the 4th strobe.
- Switch the locked do to a la wave (56818 cycles) -> note_valid drops one cycle after the first la strobe; it re-locks with note_id = 5 after the 4th la strobe.
- Period 73700, between mi and fa, outside both tolerances -> strobes continue but note_valid stays 0.
- Stop tone_in for 200000 cycles -> silent = 1 and note_valid = 0 exactly at the TIMEOUT count; a restart needs 1 + 4 edges before lock.
- Assert reset_n mid-period while locked -> immediate return to reset values; first strobe after release only at the second rise.

Source files
------------

// File: rtl/note_pkg.sv
// Shared constants for the note detector: scale table, note indices
// and FSM state encoding.
package note_pkg;

    localparam int NUM_NOTES = 8;

    // Nominal periods in 50 MHz clock cycles, do through do'.
    localparam int unsigned NOTE_PERIOD [0:NUM_NOTES-1] = '{
        95602, 85131, 75843, 71586, 63776, 56818, 50619, 47778
    };

    localparam logic [2:0] NOTE_DO  = 3'd0;
    localparam logic [2:0] NOTE_RE  = 3'd1;
    localparam logic [2:0] NOTE_MI  = 3'd2;
    localparam logic [2:0] NOTE_FA  = 3'd3;
    localparam logic [2:0] NOTE_SOL = 3'd4;
    localparam logic [2:0] NOTE_LA  = 3'd5;
    localparam logic [2:0] NOTE_SI  = 3'd6;
    localparam logic [2:0] NOTE_DO2 = 3'd7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

endpackage

// File: rtl/note_classifier.sv
// Combinational match of a measured period against the scale table.
// PERIOD_SHIFT scales the table down (0 = real 50 MHz note periods).
import note_pkg::*;

module note_classifier #(
    parameter int CNT_W        = 28,
    parameter int TOL_SHIFT    = 6,
    parameter int PERIOD_SHIFT = 0
) (
    input  logic [CNT_W-1:0] period,
    output logic             match,
    output logic [2:0]       idx
);

    logic [CNT_W:0] nom;
    logic [CNT_W:0] diff;
    logic [CNT_W:0] mag;

    // Scan from the top so the lowest matching index is the one kept.
    always_comb begin
        match = 1'b0;
        idx   = NOTE_DO;
        nom   = '0;
        diff  = '0;
        mag   = '0;
        for (int i = NUM_NOTES - 1; i >= 0; i--) begin
            nom  = (CNT_W+1)'(NOTE_PERIOD[i] >> PERIOD_SHIFT);
            diff = {1'b0, period} - nom;
            mag  = diff[CNT_W] ? (~diff + 1'b1) : diff;
            if (mag <= (nom >> TOL_SHIFT)) begin
                match = 1'b1;
                idx   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/note_detector.sv
// Measures the period of an incoming square wave and locks onto the
// matching scale note once it has been stable for LOCK_COUNT periods.
import note_pkg::*;

module note_detector #(
    parameter int CNT_W        = 28,
    parameter int TOL_SHIFT    = 6,
    parameter int LOCK_COUNT   = 4,
    parameter int TIMEOUT      = 200000,
    parameter int PERIOD_SHIFT = 0
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             tone_in,
    output logic [CNT_W-1:0] period_out,
    output logic             period_strobe,
    output logic [2:0]       note_id,
    output logic             note_valid,
    output logic             silent
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam logic [MW-1:0]    LC   = MW'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] TO_C = CNT_W'(TIMEOUT);

    logic             sync1;
    logic             sync2;
    logic             prev;
    logic             rise;
    logic [CNT_W-1:0] cnt;
    logic             timeout;
    state_t           state;
    logic [2:0]       cand;
    logic [MW-1:0]    match_cnt;
    logic [MW-1:0]    run_next;
    logic             match;
    logic [2:0]       idx;

    assign rise    = sync2 & ~prev;
    assign timeout = (cnt == TO_C);

    note_classifier #(
        .CNT_W       (CNT_W),
        .TOL_SHIFT   (TOL_SHIFT),
        .PERIOD_SHIFT(PERIOD_SHIFT)
    ) u_classifier (
        .period(period_out),
        .match (match),
        .idx   (idx)
    );

    // Length of the current same-note run, clamped once locked.
    always_comb begin
        run_next = '0;
        if (match) begin
            if (idx != cand)
                run_next = MW'(1);
            else if (match_cnt == LC)
                run_next = LC;
            else
                run_next = match_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            prev          <= 1'b0;
            cnt           <= '0;
            period_out    <= '0;
            period_strobe <= 1'b0;
        end else begin
            sync1         <= tone_in;
            sync2         <= sync1;
            prev          <= sync2;
            period_strobe <= 1'b0;
            if (rise) begin
                cnt <= '0;
                if (state != IDLE) begin
                    period_out    <= cnt + 1'b1;
                    period_strobe <= 1'b1;
                end
            end else if (!timeout) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cand       <= NOTE_DO;
            match_cnt  <= '0;
            note_id    <= NOTE_DO;
            note_valid <= 1'b0;
            silent     <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rise) begin
                        state     <= ACQUIRE;
                        match_cnt <= '0;
                        silent    <= 1'b0;
                    end
                end
                ACQUIRE, LOCKED: begin
                    if (timeout && !rise) begin
                        state      <= IDLE;
                        silent     <= 1'b1;
                        note_valid <= 1'b0;
                    end else if (period_strobe) begin
                        if (match)
                            cand <= idx;
                        match_cnt <= run_next;
                        if (run_next == LC) begin
                            state      <= LOCKED;
                            note_id    <= idx;
                            note_valid <= 1'b1;
                        end else begin
                            state      <= ACQUIRE;
                            note_valid <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_detector.sv
// Randomised self-checking bench for note_detector with a scaled-down
// note table and an edge-history reference model.
module tb_note_detector;

    localparam int CNT_W = 28;
    localparam int TO    = 1500;
    localparam int PS    = 7;
    localparam int LC    = 4;
    // Scale table divided by 128, computed by hand.
    localparam int NOM [0:7] = '{746, 665, 592, 559, 498, 443, 395, 373};

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             tone_in = 1'b0;
    logic [CNT_W-1:0] period_out;
    logic             period_strobe;
    logic [2:0]       note_id;
    logic             note_valid;
    logic             silent;

    int errors = 0;
    int checks = 0;
    int prints = 0;
    bit started = 0;

    note_detector #(
        .CNT_W       (CNT_W),
        .TOL_SHIFT   (6),
        .LOCK_COUNT  (LC),
        .TIMEOUT     (TO),
        .PERIOD_SHIFT(PS)
    ) dut (
        .clock_in     (clk),
        .reset_n      (rst_n),
        .tone_in      (tone_in),
        .period_out   (period_out),
        .period_strobe(period_strobe),
        .note_id      (note_id),
        .note_valid   (note_valid),
        .silent       (silent)
    );

    always #5 clk = ~clk;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (prints < 40) begin
                prints++;
                $display("FAIL %s: got %0d expected %0d at %0t",
                         name, act, exp, $time);
            end
        end
    endtask

    function automatic int classify(int p);
        for (int i = 0; i < 8; i++) begin
            int d;
            d = p - NOM[i];
            if (d < 0) d = -d;
            if (d <= NOM[i] / 64) return i;
        end
        return -1;
    endfunction

    // Reference model: rising edges of tone_in become visible to the
    // detector two clocks after being sampled; period = gap between them.
    int n = 0;
    bit last_tone = 0;
    int evq[$];
    bit m_active = 0;
    int last_rise = 0;
    int m_period = 0;
    bit m_strobe = 0;
    int m_id = 0;
    bit m_valid = 0;
    bit m_silent = 1;
    int run = 0;
    int run_note = 0;

    always @(posedge clk) begin : model
        int c;
        bit sp;
        if (!rst_n) begin
            evq.delete();
            last_tone = 0;
            m_active  = 0;
            m_period  = 0;
            m_strobe  = 0;
            m_id      = 0;
            m_valid   = 0;
            m_silent  = 1;
            run       = 0;
            run_note  = 0;
            last_rise = n;
        end else begin
            n++;
            sp = m_strobe;
            m_strobe = 0;
            if (sp && m_active) begin
                c = classify(m_period);
                if (c < 0) run = 0;
                else if (run > 0 && c == run_note) run++;
                else begin
                    run = 1;
                    run_note = c;
                end
                m_valid = (run >= LC);
                if (m_valid) m_id = run_note;
            end
            if (evq.size() > 0 && evq[0] + 2 == n) begin
                void'(evq.pop_front());
                if (!m_active) begin
                    m_active = 1;
                    m_silent = 0;
                    run = 0;
                end else begin
                    m_period = n - last_rise;
                    m_strobe = 1;
                end
                last_rise = n;
            end else if (m_active && n - 1 - last_rise >= TO) begin
                m_active = 0;
                m_silent = 1;
                m_valid  = 0;
            end
            if (tone_in && !last_tone) evq.push_back(n);
            last_tone = tone_in;
        end
    end

    always @(negedge clk) begin
        #1;
        if (started && rst_n) begin
            check("period_out", int'(period_out), m_period);
            check("period_strobe", int'(period_strobe), int'(m_strobe));
            check("note_id", int'(note_id), m_id);
            check("note_valid", int'(note_valid), int'(m_valid));
            check("silent", int'(silent), int'(m_silent));
        end
    end

    task automatic wave(int p, int cnt);
        for (int k = 0; k < cnt; k++) begin
            tone_in = 1'b1;
            repeat (p - p / 2) @(negedge clk);
            tone_in = 1'b0;
            repeat (p / 2) @(negedge clk);
        end
    endtask

    task automatic wait_strobe(output int w);
        w = 0;
        while (1) begin
            @(negedge clk);
            w++;
            if (period_strobe) break;
            if (w >= 20) begin
                checks++;
                errors++;
                $display("FAIL strobe_wait: no strobe within %0d cycles", w);
                break;
            end
        end
    endtask

    initial begin
        #(80000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int w;
        int p;
        int kind;
        int nt;
        int reps;
        int j;
        repeat (6) @(negedge clk) tone_in = ~tone_in;
        check("rst_period", int'(period_out), 0);
        check("rst_strobe", int'(period_strobe), 0);
        check("rst_note_id", int'(note_id), 0);
        check("rst_valid", int'(note_valid), 0);
        check("rst_silent", int'(silent), 1);
        tone_in = 1'b0;
        rst_n = 1'b1;
        started = 1;
        repeat (5) @(negedge clk);

        // do: lock on the 4th strobe
        wave(NOM[0], 4);
        check("do_pre_lock", int'(note_valid), 0);
        tone_in = 1'b1;
        wait_strobe(w);
        check("do_period", int'(period_out), 746);
        check("do_strobe_valid", int'(note_valid), 0);
        @(negedge clk);
        check("do_lock_valid", int'(note_valid), 1);
        check("do_lock_id", int'(note_id), 0);
        repeat (373 - w - 1) @(negedge clk);
        tone_in = 1'b0;
        repeat (373) @(negedge clk);

        // switch to la
        wave(NOM[5], 2);
        check("la_drop", int'(note_valid), 0);
        wave(NOM[5], 3);
        check("la_lock_valid", int'(note_valid), 1);
        check("la_lock_id", int'(note_id), 5);
        check("la_period", int'(period_out), 443);

        // between mi and fa
        wave(575, 6);
        check("gap_valid", int'(note_valid), 0);
        check("gap_period", int'(period_out), 575);

        // silence and restart
        tone_in = 1'b0;
        repeat (TO + 20) @(negedge clk);
        check("silent_flag", int'(silent), 1);
        check("silent_valid", int'(note_valid), 0);
        check("silent_period_held", int'(period_out), 575);
        wave(NOM[0], 4);
        check("restart_4_edges", int'(note_valid), 0);
        wave(NOM[0], 1);
        check("restart_5_edges", int'(note_valid), 1);
        check("restart_id", int'(note_id), 0);

        // reset mid-period while locked
        tone_in = 1'b1;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_period", int'(period_out), 0);
        check("midrst_valid", int'(note_valid), 0);
        check("midrst_silent", int'(silent), 1);
        check("midrst_id", int'(note_id), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        tone_in = 1'b0;
        repeat (300) @(negedge clk);
        check("post_rst_no_strobe", int'(period_out), 0);
        check("post_rst_active", int'(silent), 0);
        wave(NOM[0], 1);

        // randomised segments
        for (int s = 0; s < 12; s++) begin
            kind = $urandom_range(0, 5);
            if (kind <= 2) begin
                nt = $urandom_range(0, 7);
                reps = $urandom_range(1, 6);
                for (int r = 0; r < reps; r++) begin
                    j = int'($urandom_range(0, 2 * (NOM[nt] / 64)))
                        - NOM[nt] / 64;
                    wave(NOM[nt] + j, 1);
                end
            end else if (kind == 3) begin
                wave(int'($urandom_range(2, 800)), $urandom_range(1, 3));
            end else if (kind == 4) begin
                wave(int'($urandom_range(2, 3)), $urandom_range(1, 3));
            end else begin
                p = TO - 2 + int'($urandom_range(0, 4));
                wave(p, 1);
            end
        end

        tone_in = 1'b0;
        repeat (10) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
